unified_mem_arbiter: RTL

//  Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/unified_mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch and
// load/store, with round-robin fairness on conflict and one-cycle valid pulses.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_dm;
  logic             grant_dm;
  logic             grant_wr;
  logic             dm_req;
  logic             pick_dm;

  // On conflict the port opposite the previous grant wins
  always_comb begin
    dm_req   = dm_rd | dm_wr;
    pick_dm  = dm_req & (~if_req | ~last_dm);
    if_stall = ~reset & if_req & ~if_valid;
    dm_stall = ~reset & dm_req & ~dm_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_dm    <= 1'b0;
      grant_dm   <= 1'b0;
      grant_wr   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | dm_req) begin
            state      <= ISSUE;
            cnt        <= '0;
            grant_dm   <= pick_dm;
            grant_wr   <= pick_dm & dm_wr;
            last_dm    <= pick_dm;
            mem_en     <= 1'b1;
            mem_we     <= pick_dm & dm_wr;
            mem_addr   <= pick_dm ? dm_addr : if_addr;
            mem_wdata  <= pick_dm ? dm_wdata : '0;
            mem_funct3 <= pick_dm ? dm_funct3 : 3'b010;
          end
        end
        ISSUE: begin
          state      <= WAIT;
          cnt        <= '0;
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          mem_addr   <= '0;
          mem_wdata  <= '0;
          mem_funct3 <= '0;
        end
        WAIT: begin
          // Capture and valid are registered together so valid lands in DONE
          if (cnt == CNT_W'(MEM_LAT - 1)) begin
            state <= DONE;
            if (grant_dm) begin
              dm_valid <= 1'b1;
              if (!grant_wr) dm_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
